mem_bus_responder: RTL and testbench

- Memory-side responder for the CPU's shared 8-bit data / 16-bit address bus.
- Answers the control unit's ce/wre/rst strobes with a registered, wait-stated read or write into a local byte RAM.
- Returns a one-cycle ready pulse and drives read data only while its output enable is high, so the data bus can be shared with the register file.
- Sits beside the register file on data_bus/addr_bus, opposite the control unit that initiates every transaction.

---
 rtl/mem_bus_responder.sv | 127 ++++++++++++
 tb/tb_mem_bus_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Memory-side responder on the shared CPU data/address bus: registered, wait-stated
// byte RAM access with a one-cycle ready pulse and a power-up zero sweep.
module mem_bus_responder #(
    parameter int          DEPTH_W     = 8,
    parameter logic [15:0] BASE        = 16'h0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        wre,
    input  logic        mem_rst,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        rdata_oe,
    output logic        ready,
    output logic        busy
);

    localparam logic [1:0] CLEAR = 2'd0;
    localparam logic [1:0] IDLE  = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    localparam logic [3:0] WS    = 4'(WAIT_STATES);
    localparam int         WORDS = 1 << DEPTH_W;

    logic [7:0]         ram [WORDS];
    logic [1:0]         state;
    logic [DEPTH_W-1:0] sweep;
    logic [3:0]         wait_cnt;
    logic [DEPTH_W-1:0] idx;
    logic               wre_q;
    logic [7:0]         wdata_q;
    logic [7:0]         rdata_q;

    logic               hit;
    logic               acc_en;
    logic [DEPTH_W-1:0] acc_idx;
    logic               acc_wre;
    logic [7:0]         acc_wdata;

    assign hit = (addr[15:DEPTH_W] == BASE[15:DEPTH_W]);

    // RAM access fires on the edge that enters ACK: from WAIT, or straight from IDLE
    // when there are no wait states (then the live bus values are used).
    always_comb begin
        acc_en    = 1'b0;
        acc_idx   = idx;
        acc_wre   = wre_q;
        acc_wdata = wdata_q;
        if (!mem_rst) begin
            if (state == IDLE && ce && hit && WS == 4'd0) begin
                acc_en    = 1'b1;
                acc_idx   = addr[DEPTH_W-1:0];
                acc_wre   = wre;
                acc_wdata = wdata;
            end else if (state == WAIT && wait_cnt <= 4'd1) begin
                acc_en = 1'b1;
            end
        end
    end

    // NOTE: RAM has no reset branch; it is cleared by the CLEAR sweep, which keeps it
    // inferable as a plain memory array.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            ram[sweep] <= 8'h00;
        end else if (acc_en && acc_wre) begin
            ram[acc_idx] <= acc_wdata;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            sweep    <= '0;
            wait_cnt <= 4'd0;
            idx      <= '0;
            wre_q    <= 1'b0;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
        end else if (mem_rst) begin
            state    <= CLEAR;
            sweep    <= '0;
            wait_cnt <= 4'd0;
        end else begin
            if (acc_en && !acc_wre) begin
                rdata_q <= ram[acc_idx];
            end
            case (state)
                CLEAR: begin
                    sweep <= sweep + 1'b1;
                    if (sweep == {DEPTH_W{1'b1}}) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (ce && hit) begin
                        idx      <= addr[DEPTH_W-1:0];
                        wre_q    <= wre;
                        wdata_q  <= wdata;
                        wait_cnt <= WS;
                        state    <= (WS == 4'd0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= ACK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the state register directly, so the async reset clears them at once.
    assign ready    = (state == ACK);
    assign rdata_oe = (state == ACK) && !wre_q;
    assign busy     = (state == CLEAR);
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: three instances cover WAIT_STATES 1/0/3,
// a relocated BASE window, abort via mem_rst and asynchronous reset mid-ACK.
module tb_mem_bus_responder;

    typedef struct {
        logic       rd;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    localparam int WS_TAB [3] = '{1, 0, 3};

    logic        clk;
    logic        rst_n;
    logic        ce       [3];
    logic        wre      [3];
    logic        mem_rst  [3];
    logic [15:0] addr     [3];
    logic [7:0]  wdata    [3];
    logic [7:0]  rdata    [3];
    logic        rdata_oe [3];
    logic        ready    [3];
    logic        busy     [3];

    exp_t q [3][$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    mem_bus_responder #(.DEPTH_W(8), .BASE(16'h0000), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst_n(rst_n), .ce(ce[0]), .wre(wre[0]), .mem_rst(mem_rst[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .rdata_oe(rdata_oe[0]),
        .ready(ready[0]), .busy(busy[0]));

    mem_bus_responder #(.DEPTH_W(8), .BASE(16'h8000), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .ce(ce[1]), .wre(wre[1]), .mem_rst(mem_rst[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .rdata_oe(rdata_oe[1]),
        .ready(ready[1]), .busy(busy[1]));

    mem_bus_responder #(.DEPTH_W(8), .BASE(16'h0000), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n), .ce(ce[2]), .wre(wre[2]), .mem_rst(mem_rst[2]),
        .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]), .rdata_oe(rdata_oe[2]),
        .ready(ready[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops one expectation per ready pulse, checking arrival cycle and data.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("oe_implies_ready[%0d]", i),
                  int'(rdata_oe[i] && !ready[i]), 0);
            if (ready[i]) begin
                if (q[i].size() == 0) begin
                    check($sformatf("unexpected_ready[%0d]", i), 1, 0);
                end else begin
                    exp_t e;
                    e = q[i].pop_front();
                    check($sformatf("latency[%0d]", i), cyc, e.cyc);
                    check($sformatf("rdata_oe[%0d]", i), int'(rdata_oe[i]), int'(e.rd));
                    if (e.rd) begin
                        check($sformatf("rdata[%0d]", i), int'(rdata[i]), int'(e.data));
                    end
                end
            end
        end
    end

    // Issue one request at a negedge; for reads d is the expected data.
    task automatic req(input int i, input bit wr, input logic [15:0] a,
                       input logic [7:0] d, input bit push);
        ce[i]    = 1'b1;
        wre[i]   = wr;
        addr[i]  = a;
        wdata[i] = d;
        if (push) q[i].push_back('{rd: !wr, data: d, cyc: cyc + 1 + WS_TAB[i]});
        @(negedge clk);
        ce[i] = 1'b0;
        repeat (WS_TAB[i] + 3) @(negedge clk);
    endtask

    task automatic wait_busy(input int i, output int n);
        n = 0;
        while (busy[i] && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int r;
        logic [7:0] bytes [3];
        bytes = '{8'h11, 8'h22, 8'h33};
        cyc = 0;
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ce[i] = 1'b0; wre[i] = 1'b0; mem_rst[i] = 1'b0;
            addr[i] = 16'h0000; wdata[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy[0]), 1);
        check("reset_ready", int'(ready[0]), 0);
        check("reset_oe", int'(rdata_oe[0]), 0);
        check("reset_rdata", int'(rdata[0]), 0);

        // Zero sweep after reset release: exactly 256 busy cycles.
        rst_n = 1'b1;
        wait_busy(0, n);
        check("sweep_len_after_reset", n, 256);
        check("busy_ws0_after_sweep", int'(busy[1]), 0);
        check("busy_ws3_after_sweep", int'(busy[2]), 0);

        // WAIT_STATES = 1: cleared RAM, write then read-back.
        req(0, 1'b0, 16'h0042, 8'h00, 1'b1);
        req(0, 1'b1, 16'h0010, 8'hA5, 1'b1);
        req(0, 1'b0, 16'h0010, 8'hA5, 1'b1);

        // BASE = 16'h8000: a miss held for 10 cycles never responds.
        ce[1] = 1'b1; wre[1] = 1'b0; addr[1] = 16'h1234;
        r = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready[1] || rdata_oe[1]) r++;
        end
        ce[1] = 1'b0;
        @(negedge clk);
        check("miss_no_ready", r, 0);
        req(1, 1'b0, 16'h8034, 8'h00, 1'b1);

        // WAIT_STATES = 0: preload, then back-to-back reads with ce held high.
        for (int k = 0; k < 3; k++) req(1, 1'b1, 16'h8001 + 16'(k), bytes[k], 1'b1);
        ce[1] = 1'b1; wre[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            addr[1] = 16'h8001 + 16'(k);
            q[1].push_back('{rd: 1'b1, data: bytes[k], cyc: cyc + 1});
            repeat (2) @(negedge clk);
        end
        ce[1] = 1'b0;
        repeat (3) @(negedge clk);

        // WAIT_STATES = 3: write/read, then a write aborted by mem_rst mid-WAIT.
        req(2, 1'b1, 16'h0020, 8'h5A, 1'b1);
        req(2, 1'b0, 16'h0020, 8'h5A, 1'b1);
        ce[2] = 1'b1; wre[2] = 1'b1; addr[2] = 16'h0020; wdata[2] = 8'hC3;
        @(negedge clk);
        mem_rst[2] = 1'b1;
        ce[2] = 1'b0;
        @(negedge clk);
        mem_rst[2] = 1'b0;
        wait_busy(2, n);
        check("sweep_len_after_mem_rst", n, 256);
        req(2, 1'b0, 16'h0020, 8'h00, 1'b1);

        // Asynchronous reset in the middle of an ACK cycle.
        ce[0] = 1'b1; wre[0] = 1'b0; addr[0] = 16'h0010;
        @(negedge clk);
        ce[0] = 1'b0;
        @(posedge clk);
        #2;
        check("pre_reset_ready", int'(ready[0]), 1);
        check("pre_reset_rdata", int'(rdata[0]), 8'hA5);
        rst_n = 1'b0;
        #1;
        check("async_ready", int'(ready[0]), 0);
        check("async_oe", int'(rdata_oe[0]), 0);
        check("async_rdata", int'(rdata[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_busy(0, n);
        check("sweep_len_after_async", n, 256);

        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("missing_ready[%0d]", i), q[i].size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
